// File: rtl/fetch_prefetch_buffer_pkg.sv
// Shared constants and types for the Y86-64 instruction prefetch buffer.
package fetch_prefetch_buffer_pkg;

    localparam int WORD_BYTES      = 8;
    localparam int MAX_INSTR_BYTES = 10;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_WAIT  = 2'd1,
        ST_STALE = 2'd2,
        ST_FAULT = 2'd3
    } fpb_state_e;

    // Lane enable after dropping the low 'skip' bytes of an aligned word.
    function automatic logic [7:0] lane_mask(input logic [2:0] skip);
        return 8'hFF >> skip;
    endfunction

endpackage

// File: rtl/fetch_prefetch_buffer_byte_ring.sv
// Byte ring storage: masked 8-byte append at an index, 10-byte rotating read at the head.
module fetch_prefetch_buffer_byte_ring #(
    parameter int DEPTH_BYTES = 32,
    localparam int IDX_W      = $clog2(DEPTH_BYTES)
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [63:0]      i_wr_data,
    input  logic [7:0]       i_wr_be,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [79:0]      o_rd_data
);

    logic [7:0] r_mem [DEPTH_BYTES];

    // Storage is pure datapath; validity is tracked by the pointers in the parent.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int j = 0; j < 8; j++) begin
                if (i_wr_be[j]) begin
                    r_mem[i_wr_idx + IDX_W'(j)] <= i_wr_data[8*j +: 8];
                end
            end
        end
    end

    always_comb begin
        o_rd_data = '0;
        for (int k = 0; k < 10; k++) begin
            o_rd_data[8*k +: 8] = r_mem[i_rd_idx + IDX_W'(k)];
        end
    end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Instruction prefetch queue: aligned 8-byte reads ahead of fetch, 10-byte window at win_pc.
//
// state | meaning
// REQ   | idle, request next word when 8 bytes are free
// WAIT  | one read outstanding, its data will be appended
// STALE | one read outstanding but flushed by redirect, data dropped
// FAULT | read faulted, no more requests, ring drains
module fetch_prefetch_buffer
    import fetch_prefetch_buffer_pkg::*;
#(
    parameter int DEPTH_BYTES = 32,
    parameter int ADDR_W      = 64
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_redirect,
    input  logic [ADDR_W-1:0] i_redirect_pc,
    output logic              o_mem_req_valid,
    input  logic              i_mem_req_ready,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic              i_mem_rsp_valid,
    input  logic [63:0]       i_mem_rsp_data,
    input  logic              i_mem_rsp_err,
    output logic [79:0]       o_win_data,
    output logic [5:0]        o_win_avail,
    output logic [ADDR_W-1:0] o_win_pc,
    output logic              o_win_fault,
    input  logic              i_consume_valid,
    input  logic [3:0]        i_consume_len
);

    localparam int IDX_W = $clog2(DEPTH_BYTES);
    localparam int PTR_W = IDX_W + 1;

    fpb_state_e        r_state;
    fpb_state_e        w_state_nxt;
    logic              r_run;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [ADDR_W-1:0] r_win_pc;
    logic [ADDR_W-1:0] r_next_fetch;
    logic [2:0]        r_skip;

    logic [PTR_W-1:0]  w_count;
    logic [PTR_W-1:0]  w_free;
    logic [PTR_W-1:0]  w_wr_bytes;
    logic              w_req_fire;
    logic              w_rsp_take;
    logic              w_outstanding;
    logic              w_consume_ok;
    logic [79:0]       w_ring_rd;

    assign w_count    = r_wr_ptr - r_rd_ptr;
    assign w_free     = PTR_W'(DEPTH_BYTES) - w_count;
    assign w_wr_bytes = PTR_W'(4'd8 - {1'b0, r_skip});

    // r_run holds requests off until the first clock after reset release.
    assign o_mem_req_valid = r_run && (r_state == ST_REQ) && (w_free >= PTR_W'(WORD_BYTES));
    assign o_mem_addr      = r_next_fetch;
    assign o_win_pc        = r_win_pc;
    assign o_win_fault     = (r_state == ST_FAULT) && (w_count == '0);
    assign o_win_avail     = (w_count >= PTR_W'(MAX_INSTR_BYTES)) ? 6'(MAX_INSTR_BYTES) : 6'(w_count);

    assign w_req_fire    = o_mem_req_valid && i_mem_req_ready;
    assign w_rsp_take    = (r_state == ST_WAIT) && i_mem_rsp_valid && !i_mem_rsp_err && !i_redirect;
    assign w_outstanding = (((r_state == ST_WAIT) || (r_state == ST_STALE)) && !i_mem_rsp_valid)
                         || ((r_state == ST_REQ) && w_req_fire);
    assign w_consume_ok  = i_consume_valid && !i_redirect && (i_consume_len != 4'd0)
                         && ({2'b00, i_consume_len} <= o_win_avail);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_REQ:   if (w_req_fire) w_state_nxt = ST_WAIT;
            ST_WAIT:  if (i_mem_rsp_valid) w_state_nxt = i_mem_rsp_err ? ST_FAULT : ST_REQ;
            ST_STALE: if (i_mem_rsp_valid) w_state_nxt = ST_REQ;
            ST_FAULT: w_state_nxt = ST_FAULT;
            default:  w_state_nxt = ST_REQ;
        endcase
        if (i_redirect) begin
            w_state_nxt = w_outstanding ? ST_STALE : ST_REQ;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_run        <= 1'b0;
            r_rd_ptr     <= '0;
            r_wr_ptr     <= '0;
            r_win_pc     <= '0;
            r_next_fetch <= '0;
            r_skip       <= '0;
        end else begin
            r_run <= 1'b1;
            if (i_redirect) begin
                r_rd_ptr     <= r_wr_ptr;
                r_win_pc     <= i_redirect_pc;
                r_next_fetch <= {i_redirect_pc[ADDR_W-1:3], 3'b000};
                r_skip       <= i_redirect_pc[2:0];
            end else begin
                if (w_req_fire) begin
                    r_next_fetch <= r_next_fetch + ADDR_W'(WORD_BYTES);
                end
                if (w_rsp_take) begin
                    r_wr_ptr <= r_wr_ptr + w_wr_bytes;
                    r_skip   <= '0;
                end
                if (w_consume_ok) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(i_consume_len);
                    r_win_pc <= r_win_pc + ADDR_W'(i_consume_len);
                end
            end
        end
    end

    fetch_prefetch_buffer_byte_ring #(
        .DEPTH_BYTES (DEPTH_BYTES)
    ) u_ring (
        .i_clk     (i_clk),
        .i_wr_en   (w_rsp_take),
        .i_wr_idx  (r_wr_ptr[IDX_W-1:0]),
        .i_wr_data (i_mem_rsp_data >> {r_skip, 3'b000}),
        .i_wr_be   (lane_mask(r_skip)),
        .i_rd_idx  (r_rd_ptr[IDX_W-1:0]),
        .o_rd_data (w_ring_rd)
    );

    always_comb begin
        o_win_data = '0;
        for (int k = 0; k < MAX_INSTR_BYTES; k++) begin
            if (6'(k) < o_win_avail) begin
                o_win_data[8*k +: 8] = w_ring_rd[8*k +: 8];
            end
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Directed bench for the prefetch buffer with a small latency-programmable memory model.
module tb_fetch_prefetch_buffer;

    localparam int ADDR_W = 64;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_redirect;
    logic [ADDR_W-1:0] i_redirect_pc;
    logic              o_mem_req_valid;
    logic              i_mem_req_ready;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              i_mem_rsp_valid;
    logic [63:0]       i_mem_rsp_data;
    logic              i_mem_rsp_err;
    logic [79:0]       o_win_data;
    logic [5:0]        o_win_avail;
    logic [ADDR_W-1:0] o_win_pc;
    logic              o_win_fault;
    logic              i_consume_valid;
    logic [3:0]        i_consume_len;

    always #5 clk = ~clk;

    fetch_prefetch_buffer #(.DEPTH_BYTES(32), .ADDR_W(ADDR_W)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_redirect      (i_redirect),
        .i_redirect_pc   (i_redirect_pc),
        .o_mem_req_valid (o_mem_req_valid),
        .i_mem_req_ready (i_mem_req_ready),
        .o_mem_addr      (o_mem_addr),
        .i_mem_rsp_valid (i_mem_rsp_valid),
        .i_mem_rsp_data  (i_mem_rsp_data),
        .i_mem_rsp_err   (i_mem_rsp_err),
        .o_win_data      (o_win_data),
        .o_win_avail     (o_win_avail),
        .o_win_pc        (o_win_pc),
        .o_win_fault     (o_win_fault),
        .i_consume_valid (i_consume_valid),
        .i_consume_len   (i_consume_len)
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          cyc = 0;
    int          lat = 1;
    bit          pend = 0;
    int          pcnt = 0;
    logic [63:0] pend_addr = '0;
    bit          err_en = 0;
    logic [63:0] err_addr = '0;
    logic [63:0] fire_log[$];
    int          fire_cyc[$];
    int          rsp_cyc_q[$];

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [63:0] w, t;
        w = '0;
        for (int k = 0; k < 8; k++) begin
            t = a + 64'(k);
            w[8*k +: 8] = t[7:0];
        end
        return w;
    endfunction

    function automatic logic [79:0] exp_win(input logic [63:0] pc, input int n);
        logic [79:0] w;
        logic [63:0] t;
        w = '0;
        for (int k = 0; k < n && k < 10; k++) begin
            t = pc + 64'(k);
            w[8*k +: 8] = t[7:0];
        end
        return w;
    endfunction

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample the handshake before the edge, then update the memory model after it.
    task automatic tick();
        bit          f;
        logic [63:0] fa;
        @(negedge clk);
        f  = o_mem_req_valid && i_mem_req_ready;
        fa = o_mem_addr;
        @(posedge clk);
        #1;
        cyc++;
        i_redirect      = 1'b0;
        i_consume_valid = 1'b0;
        i_consume_len   = 4'd0;
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_err   = 1'b0;
        i_mem_rsp_data  = '0;
        if (f) begin
            fire_log.push_back(fa);
            fire_cyc.push_back(cyc);
            pend = 1;
            pcnt = lat;
            pend_addr = fa;
        end
        if (pend) begin
            if (pcnt <= 1) begin
                i_mem_rsp_valid = 1'b1;
                i_mem_rsp_data  = mem_word(pend_addr);
                i_mem_rsp_err   = err_en && (pend_addr == err_addr);
                rsp_cyc_q.push_back(cyc + 1);
                pend = 0;
            end else begin
                pcnt--;
            end
        end
    endtask

    task automatic clear_logs();
        fire_log.delete();
        fire_cyc.delete();
        rsp_cyc_q.delete();
    endtask

    task automatic wait_avail(input int budget, input string tag);
        int n = 0;
        while (o_win_avail == 6'd0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 80'(o_win_avail != 6'd0), 80'd1);
    endtask

    task automatic wait_fire(input int budget, input string tag);
        int n = 0;
        while (fire_log.size() == 0 && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_timeout"}, 80'(fire_log.size() != 0), 80'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_valid"}, 80'(o_mem_req_valid), 80'd0);
        check({tag, "_mem_addr"},  80'(o_mem_addr),      80'd0);
        check({tag, "_win_data"},  o_win_data,           80'd0);
        check({tag, "_win_avail"}, 80'(o_win_avail),     80'd0);
        check({tag, "_win_pc"},    80'(o_win_pc),        80'd0);
        check({tag, "_win_fault"}, 80'(o_win_fault),     80'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] exp_pc;
        bit          dip;
        bit          c;
        int          stale_cyc;

        i_redirect      = 1'b0;
        i_redirect_pc   = '0;
        i_mem_req_ready = 1'b1;
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_data  = '0;
        i_mem_rsp_err   = 1'b0;
        i_consume_valid = 1'b0;
        i_consume_len   = 4'd0;

        // reset values
        #2;
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: fill from 0 with no consume
        repeat (20) tick();
        check("t1_req_stopped", 80'(o_mem_req_valid), 80'd0);
        check("t1_num_reqs", 80'(fire_log.size()), 80'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_req_addr", (i < fire_log.size()) ? 80'(fire_log[i]) : 80'hDEAD, 80'(8 * i));
        end
        check("t1_win_data",  o_win_data, 80'h09080706050403020100);
        check("t1_win_avail", 80'(o_win_avail), 80'd10);
        check("t1_win_pc",    80'(o_win_pc), 80'd0);

        i_consume_valid = 1'b1;
        i_consume_len   = 4'd10;
        tick();
        check("t1_consume_pc",   80'(o_win_pc), 80'd10);
        check("t1_consume_data", o_win_data, 80'h13121110_0F0E0D0C0B0A);

        // zero-length consume is ignored
        i_consume_valid = 1'b1;
        i_consume_len   = 4'd0;
        tick();
        check("t1_len0_pc", 80'(o_win_pc), 80'd10);

        // 2: unaligned redirect
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h13;
        tick();
        clear_logs();
        check("t2_flush_avail", 80'(o_win_avail), 80'd0);
        check("t2_flush_pc",    80'(o_win_pc), 80'h13);
        wait_avail(20, "t2");
        check("t2_first_req",   (fire_log.size() > 0) ? 80'(fire_log[0]) : 80'hDEAD, 80'h10);
        check("t2_first_avail", 80'(o_win_avail), 80'd5);
        check("t2_first_data",  o_win_data, 80'h1716151413);
        repeat (10) tick();
        check("t2_full_data", o_win_data, 80'h1C1B1A19181716151413);
        check("t2_full_pc",   80'(o_win_pc), 80'h13);

        // 3: redirect while a slow request is outstanding
        lat = 3;
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h100;
        tick();
        clear_logs();
        wait_fire(10, "t3_fire");
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h205;
        tick();
        clear_logs();
        wait_avail(30, "t3");
        stale_cyc = (rsp_cyc_q.size() > 0) ? rsp_cyc_q[0] : 1000000;
        check("t3_req_addr",  (fire_log.size() > 0) ? 80'(fire_log[0]) : 80'hDEAD, 80'h200);
        check("t3_req_after_stale", 80'((fire_cyc.size() > 0) && (fire_cyc[0] > stale_cyc)), 80'd1);
        check("t3_avail", 80'(o_win_avail), 80'd3);
        check("t3_data",  o_win_data, 80'h070605);
        check("t3_pc",    80'(o_win_pc), 80'h205);
        lat = 1;

        // 4: greedy consume of 10 bytes against 1-cycle memory
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h300;
        tick();
        exp_pc = 64'h300;
        dip    = 0;
        for (int i = 0; i < 60; i++) begin
            c = (o_win_avail == 6'd10);
            if (c) begin
                i_consume_valid = 1'b1;
                i_consume_len   = 4'd10;
            end
            tick();
            if (c) begin
                exp_pc = exp_pc + 64'd10;
                if (o_win_avail < 6'd10) dip = 1;
            end
            check("t4_pc",   80'(o_win_pc), 80'(exp_pc));
            check("t4_data", o_win_data, exp_win(exp_pc, int'(o_win_avail)));
        end
        check("t4_dip", 80'(dip), 80'd1);
        check("t4_progress", 80'((exp_pc - 64'h300) >= 64'd100), 80'd1);

        // 5: fault with 6 bytes buffered
        err_en   = 1;
        err_addr = 64'h20;
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h1A;
        tick();
        repeat (8) tick();
        check("t5_avail",     80'(o_win_avail), 80'd6);
        check("t5_data",      o_win_data, 80'h1F1E1D1C1B1A);
        check("t5_no_fault",  80'(o_win_fault), 80'd0);
        check("t5_no_req",    80'(o_mem_req_valid), 80'd0);
        i_consume_valid = 1'b1;
        i_consume_len   = 4'd7;
        tick();
        check("t5_overlen_pc",    80'(o_win_pc), 80'h1A);
        check("t5_overlen_avail", 80'(o_win_avail), 80'd6);
        i_consume_valid = 1'b1;
        i_consume_len   = 4'd6;
        tick();
        check("t5_drain_avail", 80'(o_win_avail), 80'd0);
        check("t5_drain_pc",    80'(o_win_pc), 80'h20);
        check("t5_fault",       80'(o_win_fault), 80'd1);
        repeat (3) tick();
        check("t5_fault_hold",  80'(o_win_fault), 80'd1);
        check("t5_no_req_hold", 80'(o_mem_req_valid), 80'd0);
        err_en = 0;
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h40;
        tick();
        check("t5_fault_clr", 80'(o_win_fault), 80'd0);
        check("t5_redir_pc",  80'(o_win_pc), 80'h40);

        // 6: reset in the middle of WAIT
        lat = 3;
        i_redirect    = 1'b1;
        i_redirect_pc = 64'h80;
        tick();
        clear_logs();
        wait_fire(10, "t6_fire");
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_rst");
        repeat (5) tick();
        rst_n = 1'b1;
        lat = 1;
        clear_logs();
        repeat (20) tick();
        check("t6_first_req", (fire_log.size() > 0) ? 80'(fire_log[0]) : 80'hDEAD, 80'd0);
        check("t6_data",  o_win_data, 80'h09080706050403020100);
        check("t6_avail", 80'(o_win_avail), 80'd10);
        check("t6_pc",    80'(o_win_pc), 80'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
